// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART debug/loader bus initiator:
// command opcodes, the default acknowledge byte and the FSM state encoding.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WR           = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD           = 8'h52;  // 'R'
    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h06;  // ASCII ACK

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ADDR    = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_REQ     = 3'd3;
    localparam state_t ST_BUS_WR  = 3'd4;
    localparam state_t ST_BUS_RD  = 3'd5;
    localparam state_t ST_TX_ACK  = 3'd6;
    localparam state_t ST_TX_DATA = 3'd7;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog for a frame being received. Counts idle cycles while
// 'run' is high, restarts on every received byte, and raises 'expire'
// combinationally in the cycle the limit is reached with no byte arriving.
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    logic [31:0] idle_cnt;

    assign expire = run && !clear && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Idle counter: zero outside a frame, on each byte and after an abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!run || clear || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator. Parses 'W' (addr, data) and 'R' (addr) frames
// from the receive byte stream, performs one peripheral bus cycle once the
// arbiter grants the bus, and answers with an ACK byte or four data bytes.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data,
    output logic        frame_err
);

    state_t      state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic        timeout_run;
    logic        timeout_expire;
    logic        tx_fire;

    assign timeout_run = (state == ST_ADDR) || (state == ST_DATA);
    assign tx_fire     = tx_valid && tx_ready;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .clk   (clk),
        .reset (reset),
        .run   (timeout_run),
        .clear (rx_valid),
        .expire(timeout_expire)
    );

    // Outputs are pure decodes of state and the two shift registers, so a
    // reset edge clears every strobe by the following cycle.
    assign bus_req    = (state == ST_REQ) || (state == ST_BUS_WR) || (state == ST_BUS_RD);
    assign MemWrite   = (state == ST_BUS_WR);
    assign MemRead    = (state == ST_BUS_RD);
    assign Address    = addr_reg;
    assign Write_data = data_reg;
    assign tx_valid   = (state == ST_TX_ACK) || (state == ST_TX_DATA);
    assign tx_data    = (state == ST_TX_ACK)  ? ACK_BYTE       :
                        (state == ST_TX_DATA) ? data_reg[31:24] : 8'h00;

    // Frame parser, bus sequencer and response serializer.
    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the pre-edge values of state, byte_cnt and the shift registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            addr_reg  <= '0;
            data_reg  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
                        is_write <= (rx_data == CMD_WR);
                        byte_cnt <= 2'd0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (timeout_expire) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end else if (rx_valid) begin
                        addr_reg <= {addr_reg[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= is_write ? ST_DATA : ST_REQ;
                        end
                    end
                end
                ST_DATA: begin
                    if (timeout_expire) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end else if (rx_valid) begin
                        data_reg <= {data_reg[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state <= is_write ? ST_BUS_WR : ST_BUS_RD;
                    end
                end
                ST_BUS_WR: begin
                    state <= ST_TX_ACK;
                end
                ST_BUS_RD: begin
                    data_reg <= Read_data;
                    byte_cnt <= 2'd0;
                    state    <= ST_TX_DATA;
                end
                ST_TX_ACK: begin
                    if (tx_fire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_TX_DATA: begin
                    if (tx_fire) begin
                        data_reg <= {data_reg[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus pushes expected bus/tx/error
// events computed from a memory-map reference model; a negedge monitor pops
// and compares them whenever the DUT produces an event.
`timescale 1ns/1ps
module tb_uart_bus_master;

    localparam int         TO      = 16;
    localparam logic [7:0] ACK     = 8'h06;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data = 32'h0;
    logic        frame_err;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(ACK)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .frame_err(frame_err)
    );

    typedef enum int {EV_WR, EV_RD, EV_TX, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_edge = 0;
    bit          stall_mode = 1'b0;
    bit          rand_gnt = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] periph  [logic [31:0]];
    logic        prev_stalled = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pop_check(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d a=%h d=%h expected none (cycle %0d)", k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 80'(k), 80'(e.kind));
            case (e.kind)
                EV_WR:   begin check("wr_addr", a, e.a); check("wr_data", d, e.d); end
                EV_RD:   check("rd_addr", a, e.a);
                EV_TX:   check("tx_byte", a, e.a);
                default: check("err_cycle", a, e.a);
            endcase
        end
    endtask

    function automatic ev_t mk(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    // Reference model: a write stores and is acknowledged; a read returns the
    // stored word most-significant byte first (unwritten words read as zero).
    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(mk(EV_WR, a, d));
        exp_q.push_back(mk(EV_TX, 32'(ACK), 32'h0));
        ref_mem[a] = d;
    endtask

    task automatic expect_read(input logic [31:0] a, input bit with_tx);
        logic [31:0] v;
        v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        exp_q.push_back(mk(EV_RD, a, 32'h0));
        if (with_tx) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(mk(EV_TX, 32'((v >> (8 * i)) & 32'hFF), 32'h0));
        end
    endtask

    // Called at posedge+1; presents one byte for one cycle then idles 'gap' cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        last_edge = cyc;
        rx_valid  = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input bit wr, input logic [31:0] a, input logic [31:0] d, input int gap_max);
        send_byte(wr ? 8'h57 : 8'h52, $urandom_range(0, gap_max));
        for (int i = 3; i >= 0; i--) send_byte(8'((a >> (8 * i)) & 32'hFF), $urandom_range(0, gap_max));
        if (wr) begin
            for (int i = 3; i >= 0; i--) send_byte(8'((d >> (8 * i)) & 32'hFF), (i == 0) ? 0 : $urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
        check(name, 80'(exp_q.size()), 80'd0);
        exp_q.delete();
    endtask

    task automatic wait_negedge_for_tx_valid(input string name);
        int t = 0;
        @(negedge clk);
        while (!tx_valid && t < 200) begin @(negedge clk); t++; end
        check(name, 80'(tx_valid), 80'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {tx_valid, tx_data, bus_req, MemRead, MemWrite, Address, Write_data, frame_err}, 80'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmit-side sink: random acceptance, or exactly 5 wait cycles per byte.
    initial forever begin
        @(posedge clk); #1;
        if (!tx_valid) begin
            wait_cnt = 0;
            tx_ready = stall_mode ? 1'b0 : 1'($urandom_range(0, 1));
        end else if (stall_mode) begin
            tx_ready = (wait_cnt == 5);
            wait_cnt = tx_ready ? 0 : wait_cnt + 1;
        end else begin
            tx_ready = 1'($urandom_range(0, 1));
        end
        if (rand_gnt) bus_gnt = 1'($urandom_range(0, 1));
    end

    // Peripheral memory plus event monitor, both sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (MemWrite) periph[Address] = Write_data;
        Read_data = periph.exists(Address) ? periph[Address] : 32'h0;
        if (MemWrite) pop_check(EV_WR, Address, Write_data);
        if (MemRead) pop_check(EV_RD, Address, 32'h0);
        if (tx_valid && tx_ready) pop_check(EV_TX, 32'(tx_data), 32'h0);
        if (frame_err) pop_check(EV_ERR, 32'(cyc), 32'h0);
        if (prev_stalled && reset) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
        prev_stalled = tx_valid && !tx_ready;
        prev_data    = tx_data;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] addr_pool [4];

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed write, grant tied high.
        expect_write(32'h4000_0010, 32'h0000_0005);
        send_frame(1'b1, 32'h4000_0010, 32'h0000_0005, 0);
        wait_drain("write_frame");

        // Read with five wait cycles per transmitted byte.
        periph[32'h100]  = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        stall_mode = 1'b1;
        expect_read(32'h100, 1'b1);
        send_frame(1'b0, 32'h100, 32'h0, 0);
        wait_drain("read_stalled");
        stall_mode = 1'b0;

        // Grant withheld for 20 cycles after a full frame.
        bus_gnt = 1'b0;
        d = $urandom();
        expect_write(32'h200, d);
        send_frame(1'b1, 32'h200, d, 2);
        repeat (20) begin
            @(negedge clk);
            check("gnt_wait", {bus_req, MemRead, MemWrite}, 3'b100);
        end
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        wait_drain("gnt_late");

        // Timeout abort, then a read proving recovery.
        send_byte(8'h57, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        exp_q.push_back(mk(EV_ERR, 32'(last_edge + TO), 32'h0));
        wait_drain("timeout");
        expect_read(32'h4000_0010, 1'b1);
        send_frame(1'b0, 32'h4000_0010, 32'h0, 1);
        wait_drain("read_after_timeout");

        // Garbage before a valid frame.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h41, 0);
        d = $urandom();
        expect_write(32'h104, d);
        send_frame(1'b1, 32'h104, d, 1);
        wait_drain("garbage_then_write");

        // A complete write frame sent during TX_DATA must be dropped.
        stall_mode = 1'b1;
        expect_read(32'h100, 1'b1);
        send_frame(1'b0, 32'h100, 32'h0, 0);
        wait_negedge_for_tx_valid("tx_data_start");
        @(posedge clk); #1;
        send_byte(8'h57, 0);
        for (int i = 0; i < 7; i++) send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        wait_drain("rx_during_tx");
        stall_mode = 1'b0;

        // Reset during BUS_RD.
        expect_read(32'h100, 1'b0);
        send_frame(1'b0, 32'h100, 32'h0, 0);
        begin
            int t = 0;
            @(negedge clk);
            while (!MemRead && t < 100) begin @(negedge clk); t++; end
            check("bus_rd_reached", 80'(MemRead), 80'd1);
        end
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_in_bus_rd");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        wait_drain("after_reset_bus_rd");

        // Reset during TX_DATA.
        stall_mode = 1'b1;
        expect_read(32'h100, 1'b0);
        send_frame(1'b0, 32'h100, 32'h0, 0);
        wait_negedge_for_tx_valid("tx_data_before_reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_in_tx_data");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        wait_drain("after_reset_tx_data");
        stall_mode = 1'b0;

        // Randomized frames with a jittery grant.
        addr_pool[0] = 32'h100;
        addr_pool[1] = 32'h104;
        addr_pool[2] = 32'h4000_0010;
        addr_pool[3] = 32'h8000_0F00;
        rand_gnt = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 4) == 4) ? $urandom() : addr_pool[$urandom_range(0, 3)];
            d = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                expect_write(a, d);
                send_frame(1'b1, a, d, 3);
            end else begin
                expect_read(a, 1'b1);
                send_frame(1'b0, a, 32'h0, 3);
            end
            wait_drain("random_frame");
        end
        rand_gnt = 1'b0;
        bus_gnt  = 1'b1;

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Debug/loader bus initiator. Consumes a byte stream from the UART receive path, parses read/write command frames and drives the same MemRead/MemWrite/Address/Write_data/Read_data peripheral bus the CPU uses. Write frames are acknowledged and read data is returned through the UART transmit path. An external arbiter grants it the bus ahead of the CPU data port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 2_000_000 — idle cycles allowed between bytes inside a frame before abort; minimum 2.
- ACK_BYTE, 8'h06 — byte returned after a completed write.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; the block is held in reset while reset==0 at a rising edge.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_valid  out  1  byte offered to the UART transmitter.
- tx_data  out  8  byte offered; stable while tx_valid==1.
- tx_ready  in  1  transmitter accepts; a transfer occurs on a cycle with tx_valid&&tx_ready.
- bus_req  out  1  bus request to the arbiter.
- bus_gnt  in  1  bus grant.
- MemRead  out  1  bus read strobe.
- MemWrite  out  1  bus write strobe.
- Address  out  32  bus address.
- Write_data  out  32  bus write data.
- Read_data  in  32  bus read data; combinational response to Address/MemRead.
- frame_err  out  1  one-cycle pulse on timeout abort.

## Operation
- Frame formats. All multi-byte fields are big-endian.
  - Write: 8'h57, A3..A0, D3..D0.
  - Read: 8'h52, A3..A0.
- IDLE handling:
  - Any other command byte is discarded and the block stays in IDLE.
- States and transitions:
  - IDLE: rx 57/52 latches the opcode, clears byte counter → ADDR.
  - ADDR: each rx byte shifts into addr_reg (addr_reg = {addr_reg[23:0], rx_data}). After the 4th byte: write → DATA, read → REQ.
  - DATA: shifts into data_reg the same way. After the 4th byte → REQ.
  - REQ: bus_req=1. On bus_gnt=1 → write goes to BUS_WR, read goes to BUS_RD.
  - BUS_WR: MemWrite=1 for exactly one cycle → TX_ACK.
  - BUS_RD: MemRead=1 for exactly one cycle. Read_data is captured into data_reg at the end of that cycle → TX_DATA.
  - TX_ACK: tx_data=ACK_BYTE. On transfer → IDLE.
  - TX_DATA: tx_data=data_reg[31:24]. On each transfer data_reg shifts left 8. After the 4th transfer → IDLE.
- bus_req is 1 in REQ, BUS_WR and BUS_RD only.
- Address and Write_data always reflect addr_reg and data_reg. MemRead and MemWrite are 0 outside their states.
- Byte counter is 2 bits and wraps 3→0 on the final byte of each field.
- rx bytes are ignored in REQ, BUS_*, and TX_* states; no buffering.
- Timeout:
  - In ADDR or DATA, a 32-bit counter increments on every cycle without rx_valid and clears on rx_valid.
  - When the counter equals TIMEOUT_CYCLES-1 and no byte arrives that cycle: → IDLE and frame_err=1 for one cycle.
  - The counter is cleared on every entry to ADDR.
- A 57/52 byte arriving mid-frame is treated as data, not as a resync.

## Timing
- Reset values: tx_valid=0, tx_data=0, bus_req=0, MemRead=0, MemWrite=0, Address=0, Write_data=0, frame_err=0; state=IDLE, counters=0.
- Reset asserted mid-frame or mid-bus-cycle returns to IDLE at that edge. Strobes drop on the next cycle, with no partial transfer completed.
- Write: last data byte strobe at edge N → REQ at N+1. With bus_gnt already high, MemWrite is high in cycle N+2. tx_valid rises in cycle N+3.
- Read: the same path with MemRead in place of MemWrite. The first data byte is offered in cycle N+3.
- bus_gnt dropping while in REQ just extends REQ. Grant is not rechecked in BUS_*; the arbiter must hold grant while bus_req=1.
- tx_valid stays high and tx_data stable until transfer. Back-to-back transfers are allowed: a new byte is presented the cycle after a transfer.

## Structure
- Shared package holds: opcode constants CMD_WR=8'h57 and CMD_RD=8'h52, the state enum, and the default ACK_BYTE.
- One natural sub-module: frame_timeout (counter, clear, expire pulse), parameterised by TIMEOUT_CYCLES.
- The FSM, shift registers and bus drive stay in the top.

## Test plan
- Write frame 57 40 00 00 10 00 00 00 05 with gnt tied high → one MemWrite cycle with Address=32'h4000_0010 and Write_data=32'h0000_0005, then tx byte 06.
- Preload 32'h0000_0100 with 32'hDEADBEEF, send read frame 52 00 00 01 00 → one MemRead cycle, then tx bytes DE AD BE EF in order. Hold tx_ready low for 5 cycles per byte; tx_data must stay stable while waiting.
- Hold bus_gnt low for 20 cycles after a full frame → bus_req high throughout, no strobes, and a single strobe once grant is given.
- With TIMEOUT_CYCLES=16, send 57 11 22 then stop → frame_err pulses once after 16 idle cycles and the block returns to IDLE. A subsequent full read frame then works.
- Garbage bytes 00 FF 41 before a valid frame are ignored. Bytes sent while TX_DATA is active are dropped, with no bus activity.
- Drive reset low in BUS_RD and in TX_DATA → all outputs are at their reset values the next cycle, and no further tx bytes follow.
